// File: rtl/irq_pkg.sv
// Shared constants and types for the machine-mode interrupt front end.
package irq_pkg;

   // mcause exception codes for the machine interrupts handled here
   localparam logic [3:0] CAUSE_NONE = 4'd0;
   localparam logic [3:0] CAUSE_MSI  = 4'd3;
   localparam logic [3:0] CAUSE_MTI  = 4'd7;
   localparam logic [3:0] CAUSE_MEI  = 4'd11;

   // bit positions of the sources inside mip / mie
   localparam int IDX_MSI = 3;
   localparam int IDX_MTI = 7;
   localparam int IDX_MEI = 11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PEND  = 2'd1,
      ST_TAKEN = 2'd2
   } irq_state_e;

   // Fixed priority MEI > MSI > MTI; returns CAUSE_NONE when nothing is pending.
   function automatic logic [3:0] arb_cause(input logic p_mei, input logic p_msi, input logic p_mti);
      logic [3:0] c;
      c = CAUSE_NONE;
      if (p_mei)      c = CAUSE_MEI;
      else if (p_msi) c = CAUSE_MSI;
      else if (p_mti) c = CAUSE_MTI;
      return c;
   endfunction

   // Is the source behind a latched cause still pending-and-enabled?
   function automatic logic cause_pending(input logic [3:0] cause, input logic p_mei,
                                          input logic p_msi, input logic p_mti);
      logic p;
      case (cause)
         CAUSE_MEI: p = p_mei;
         CAUSE_MSI: p = p_msi;
         CAUSE_MTI: p = p_mti;
         default:   p = 1'b0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/m_irq_sync.sv
// Flop-chain synchroniser for a level signal crossing into the clk domain.
module m_irq_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // shift the async level through STAGES flops; output is the last stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) chain <= '0;
      else       chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/m_irq_ctrl.sv
// Machine interrupt front end: mie register, mip read view, priority arbiter
// and the request FSM that hands one frozen cause to the core.
//
// Handshake: irq_req is a registered level. While irq_req=1, irq_cause is stable.
// The core accepts by driving irq_ack=1 for a cycle in which irq_req=1; irq_req
// drops on the next cycle. irq_ack at any other time is ignored. The request may
// also be withdrawn (no ack) if its source or mstatus_mie goes away; an ack in
// the same cycle as a withdraw condition is still honoured.
module m_irq_ctrl
   import irq_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        msip_i,
   input  logic        mtip_i,
   input  logic        meip_async,
   input  logic        mstatus_mie,
   input  logic        mie_we,
   input  logic [31:0] mie_wdata,
   output logic [31:0] mie_rdata,
   output logic [31:0] mip_rdata,
   output logic        irq_req,
   output logic [3:0]  irq_cause,
   input  logic        irq_ack,
   output irq_state_e  state_dbg
);

   logic       meip_s;
   logic       mie_msi, mie_mti, mie_mei;
   logic       p_msi, p_mti, p_mei;
   logic       eligible;
   logic       seen_mie_low;
   irq_state_e state;

   // external pin is asynchronous; everything else is already in clk domain
   m_irq_sync #(.STAGES(SYNC_STAGES)) u_meip_sync (
      .clk   (clk),
      .reset (reset),
      .d     (meip_async),
      .q     (meip_s)
   );

   // only the three implemented enable bits are stored
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mie_msi <= 1'b0;
         mie_mti <= 1'b0;
         mie_mei <= 1'b0;
      end else if (mie_we) begin
         mie_msi <= mie_wdata[IDX_MSI];
         mie_mti <= mie_wdata[IDX_MTI];
         mie_mei <= mie_wdata[IDX_MEI];
      end
   end

   // unimplemented write bits are deliberately dropped
   logic unused_wdata;
   assign unused_wdata = ^{mie_wdata[31:12], mie_wdata[10:8], mie_wdata[6:4], mie_wdata[2:0]};

   assign mie_rdata = {20'b0, mie_mei, 3'b0, mie_mti, 3'b0, mie_msi, 3'b0};
   assign mip_rdata = {20'b0, meip_s, 3'b0, mtip_i, 3'b0, msip_i, 3'b0};

   assign p_msi    = msip_i & mie_msi;
   assign p_mti    = mtip_i & mie_mti;
   assign p_mei    = meip_s & mie_mei;
   assign eligible = mstatus_mie & (p_msi | p_mti | p_mei);

   // request FSM; irq_req/irq_cause are registered here so nothing reaches them combinationally
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         irq_req      <= 1'b0;
         irq_cause    <= CAUSE_NONE;
         seen_mie_low <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (eligible) begin
                  state     <= ST_PEND;
                  irq_req   <= 1'b1;
                  irq_cause <= arb_cause(p_mei, p_msi, p_mti);
               end
            end
            ST_PEND: begin
               if (irq_ack) begin
                  state        <= ST_TAKEN;
                  irq_req      <= 1'b0;
                  irq_cause    <= CAUSE_NONE;
                  seen_mie_low <= 1'b0;
               end else if (!mstatus_mie || !cause_pending(irq_cause, p_mei, p_msi, p_mti)) begin
                  state     <= ST_IDLE;
                  irq_req   <= 1'b0;
                  irq_cause <= CAUSE_NONE;
               end
            end
            ST_TAKEN: begin
               // core clears mstatus.MIE on trap entry and restores it on mret
               if (!seen_mie_low) begin
                  if (!mstatus_mie) seen_mie_low <= 1'b1;
               end else if (mstatus_mie) begin
                  state        <= ST_IDLE;
                  seen_mie_low <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               irq_req   <= 1'b0;
               irq_cause <= CAUSE_NONE;
            end
         endcase
      end
   end

   assign state_dbg = state;

endmodule
